// File: rtl/hex_decimal_display_ctrl.sv
// Eight-digit decimal display sequencer: latches CPU io2 writes, converts them to BCD
// with a one-shift-per-clock double-dabble engine and drives active-low HEX segments.
//
// state | meaning
// IDLE  | waiting for io_we, display holds last value
// CONV  | 32 double-dabble iterations in flight, writes are parked in pend_data
// LOAD  | BCD result copied to display, next conversion started if one is waiting
module hex_decimal_display_ctrl #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_we,
    input  logic [31:0] io_wdata,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_ZERO  = 7'h40;
    localparam logic [55:0] HEX_RST   = BLANK_LZ ? {{7{SEG_BLANK}}, SEG_ZERO}
                                                 : {8{SEG_ZERO}};

    state_t        state_q, state_d;
    logic [71:0]   sr_q, sr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic          pend_valid_q, pend_valid_d;
    logic [39:0]   disp_q, disp_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [55:0]   hex_q, hex_d;

    // One double-dabble iteration; nibbles never exceed 12 here so no inter-nibble carry.
    function automatic logic [71:0] dd_step(input logic [71:0] s);
        logic [71:0] r;
        r = s;
        for (int i = 0; i < 10; i++) begin
            if (r[32 + 4*i +: 4] >= 4'd5)
                r[32 + 4*i +: 4] = r[32 + 4*i +: 4] + 4'd3;
        end
        return {r[70:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Walk from the top digit down; blanking stops at the first non-zero digit.
    function automatic logic [55:0] draw(input logic [39:0] d, input logic ov);
        logic [55:0] h;
        logic        lz;
        logic [3:0]  dig;
        h  = '0;
        lz = BLANK_LZ && !ov;
        for (int k = 7; k >= 0; k--) begin
            dig = d[4*k +: 4];
            if (k != 0 && lz && dig == 4'd0) begin
                h[7*k +: 7] = SEG_BLANK;
            end else begin
                h[7*k +: 7] = seg7(dig);
                lz = 1'b0;
            end
        end
        return h;
    endfunction

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        hex_d        = hex_q;

        case (state_q)
            IDLE: begin
                if (io_we) begin
                    sr_d    = {40'd0, io_wdata};
                    cnt_d   = 5'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = dd_step(sr_q);
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = LOAD;
                if (io_we) begin
                    pend_data_d  = io_wdata;
                    pend_valid_d = 1'b1;
                end
            end
            LOAD: begin
                disp_d       = sr_q[71:32];
                ovf_d        = |sr_q[71:64];
                hex_d        = draw(sr_q[71:32], |sr_q[71:64]);
                done_d       = 1'b1;
                pend_valid_d = 1'b0;
                cnt_d        = 5'd0;
                if (io_we) begin
                    sr_d    = {40'd0, io_wdata};
                    state_d = CONV;
                end else if (pend_valid_q) begin
                    sr_d    = {40'd0, pend_data_q};
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            hex_q        <= HEX_RST;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            hex_q        <= hex_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign HEX0 = hex_q[6:0];
    assign HEX1 = hex_q[13:7];
    assign HEX2 = hex_q[20:14];
    assign HEX3 = hex_q[27:21];
    assign HEX4 = hex_q[34:28];
    assign HEX5 = hex_q[41:35];
    assign HEX6 = hex_q[48:42];
    assign HEX7 = hex_q[55:49];

endmodule

// File: tb/tb_hex_decimal_display_ctrl.sv
// Bench for hex_decimal_display_ctrl: two instances (blanking on/off) against a
// cycle-level behavioural model plus directed literal checks.
module tb_hex_decimal_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        io_we;
    logic [31:0] io_wdata;

    logic        busy_a, done_a, ovf_a;
    logic [6:0]  a0, a1, a2, a3, a4, a5, a6, a7;
    logic        busy_b, done_b, ovf_b;
    logic [6:0]  b0, b1, b2, b3, b4, b5, b6, b7;

    hex_decimal_display_ctrl #(.BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_wdata(io_wdata),
        .busy(busy_a), .done(done_a), .ovf(ovf_a),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3),
        .HEX4(a4), .HEX5(a5), .HEX6(a6), .HEX7(a7)
    );

    hex_decimal_display_ctrl #(.BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_wdata(io_wdata),
        .busy(busy_b), .done(done_b), .ovf(ovf_b),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3),
        .HEX4(b4), .HEX5(b5), .HEX6(b6), .HEX7(b7)
    );

    logic [55:0] hex_a, hex_b;
    assign hex_a = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign hex_b = {b7, b6, b5, b4, b3, b2, b1, b0};

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input longint unsigned d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Display image of a value from plain decimal arithmetic.
    function automatic logic [55:0] model_hex(input longint unsigned v, input bit blank);
        logic [55:0]     r;
        longint unsigned lo, p;
        bit              ov;
        r  = '0;
        ov = (v > 64'd99_999_999);
        lo = v % 64'd100_000_000;
        p  = 1;
        for (int k = 0; k < 8; k++) begin
            if (blank && !ov && k > 0 && lo < p)
                r[7*k +: 7] = 7'h7F;
            else
                r[7*k +: 7] = seg_of((lo / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Transaction-level model: a conversion lands 33 edges after it starts.
    longint unsigned m_disp = 0;
    longint unsigned m_val  = 0;
    longint unsigned m_pend = 0;
    bit              m_active = 0;
    bit              m_pend_v = 0;
    bit              m_done   = 0;
    int              m_upd    = 0;
    int              cyc      = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_disp = 0; m_active = 0; m_pend_v = 0; m_done = 0;
            end else begin
                cyc++;
                m_done = 0;
                if (!m_active) begin
                    if (io_we) begin
                        m_active = 1; m_val = {32'd0, io_wdata}; m_upd = cyc + 33;
                    end
                end else if (cyc == m_upd) begin
                    m_disp = m_val;
                    m_done = 1;
                    if (io_we) begin
                        m_val = {32'd0, io_wdata}; m_upd = cyc + 33;
                    end else if (m_pend_v) begin
                        m_val = m_pend; m_upd = cyc + 33;
                    end else begin
                        m_active = 0;
                    end
                    m_pend_v = 0;
                end else if (io_we) begin
                    m_pend = {32'd0, io_wdata}; m_pend_v = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy_a", {63'd0, busy_a}, {63'd0, m_active});
                chk("busy_b", {63'd0, busy_b}, {63'd0, m_active});
                chk("done_a", {63'd0, done_a}, {63'd0, m_done});
                chk("done_b", {63'd0, done_b}, {63'd0, m_done});
                chk("ovf_a", {63'd0, ovf_a}, {63'd0, (m_disp > 64'd99_999_999)});
                chk("ovf_b", {63'd0, ovf_b}, {63'd0, (m_disp > 64'd99_999_999)});
                chk("hex_a", {8'd0, hex_a}, {8'd0, model_hex(m_disp, 1'b1)});
                chk("hex_b", {8'd0, hex_b}, {8'd0, model_hex(m_disp, 1'b0)});
            end
        end
    end

    // One clock edge with the given write strobe; returns #1 after the edge.
    task automatic tick(input logic we, input logic [31:0] d);
        io_we = we;
        io_wdata = d;
        @(posedge clk);
        #1;
        io_we = 1'b0;
    endtask

    task automatic write_wait(input logic [31:0] v, output int lat, output int nd);
        lat = -1;
        nd  = 0;
        tick(1'b1, v);
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 32'd0);
            if (done_a) begin
                nd++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    localparam logic [55:0] RST_A = {{7{7'h7F}}, 7'h40};
    localparam logic [55:0] ALL0  = {8{7'h40}};
    localparam logic [55:0] ALL9  = {8{7'h10}};

    initial begin
        int lat, nd, lat1, lat2, nd_bb, blow;
        logic [55:0] h1, h2;
        io_we = 1'b0;
        io_wdata = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hex_a", {8'd0, hex_a}, {8'd0, RST_A});
        chk("rst_hex_b", {8'd0, hex_b}, {8'd0, ALL0});
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        rst_n = 1'b1;
        tick(1'b0, 32'd0);

        write_wait(32'd12345, lat, nd);
        chk("lat_12345", lat, 33);
        chk("ndone_12345", nd, 1);
        chk("hex_12345", {8'd0, hex_a},
            {8'd0, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        chk("busy_after", {63'd0, busy_a}, 64'd0);

        write_wait(32'd0, lat, nd);
        chk("hex_0_a", {8'd0, hex_a}, {8'd0, RST_A});
        chk("hex_0_b", {8'd0, hex_b}, {8'd0, ALL0});
        chk("ovf_0", {63'd0, ovf_a}, 64'd0);

        write_wait(32'd99_999_999, lat, nd);
        chk("hex_max_a", {8'd0, hex_a}, {8'd0, ALL9});
        chk("ovf_max", {63'd0, ovf_a}, 64'd0);

        write_wait(32'd100_000_000, lat, nd);
        chk("hex_1e8_a", {8'd0, hex_a}, {8'd0, ALL0});
        chk("ovf_1e8", {63'd0, ovf_a}, 64'd1);

        write_wait(32'hFFFF_FFFF, lat, nd);
        chk("hex_ffff_a", {8'd0, hex_a},
            {8'd0, 7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12});
        chk("ovf_ffff", {63'd0, ovf_a}, 64'd1);

        // Writes at E0, E5, E10: 22 is superseded by 33.
        lat1 = -1; lat2 = -1; nd_bb = 0; blow = 0; h1 = '0; h2 = '0;
        for (int e = 0; e <= 70; e++) begin
            if (e == 0)       tick(1'b1, 32'd11);
            else if (e == 5)  tick(1'b1, 32'd22);
            else if (e == 10) tick(1'b1, 32'd33);
            else              tick(1'b0, 32'd0);
            if (done_a) begin
                nd_bb++;
                if (lat1 < 0) begin lat1 = e; h1 = hex_a; end
                else if (lat2 < 0) begin lat2 = e; h2 = hex_a; end
            end
            if (e < 66 && !busy_a) blow++;
        end
        chk("bb_lat1", lat1, 33);
        chk("bb_lat2", lat2, 66);
        chk("bb_ndone", nd_bb, 2);
        chk("bb_busy_gap", blow, 0);
        chk("bb_hex11", {8'd0, h1}, {8'd0, {6{7'h7F}}, 7'h79, 7'h79});
        chk("bb_hex33", {8'd0, h2}, {8'd0, {6{7'h7F}}, 7'h30, 7'h30});

        // Reset in the middle of converting 777.
        tick(1'b1, 32'd777);
        for (int e = 1; e <= 15; e++) tick(1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_hex_a", {8'd0, hex_a}, {8'd0, RST_A});
        chk("midrst_hex_b", {8'd0, hex_b}, {8'd0, ALL0});
        chk("midrst_busy", {63'd0, busy_a}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nd = 0;
        for (int e = 18; e <= 100; e++) begin
            tick(1'b0, 32'd0);
            if (done_a) nd++;
        end
        chk("midrst_nodone", nd, 0);

        // io_we held high: updates every 33 edges, last pending value lands later.
        nd = 0;
        for (int e = 0; e < 70; e++) begin
            tick(1'b1, 32'd1000 + e);
            if (done_a) nd++;
        end
        chk("held_ndone", nd, 2);
        for (int e = 0; e < 80; e++) tick(1'b0, 32'd0);
        chk("held_hex1069", {8'd0, hex_a},
            {8'd0, {4{7'h7F}}, 7'h79, 7'h40, 7'h02, 7'h10});

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
